uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the existing uart_tx path in ksenios.
- Oversamples the asynchronous serial input 16x, deframes 8N1 characters (LSB first), and buffers received bytes in an internal FIFO.
- Exposes the FIFO head with empty/full status plus sticky error flags. These drive the CPU/host side and the seven-segment status display.

Parameters:
- DVSR, 54, clock cycles per oversample tick (100 MHz / (16*115200) ≈ 54); tick period = DVSR cycles.
- DBIT, 8, data bits per character.
- SB_TICK, 16, oversample ticks in the stop bit.
- FIFO_W, 4, FIFO address width; depth = 2**FIFO_W (16).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high; clears all state.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_uart  input  1  pop request; pops the FIFO head on the clock edge where it is sampled high.
- clr_err  input  1  clears frame_err and overrun.
- r_data  output  DBIT  FIFO head, first-word fall-through; 0 when empty.
- rx_empty  output  1  FIFO empty.
- rx_full  output  1  FIFO full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a valid byte was dropped because the FIFO was full.

Behaviour:
- Reset values: r_data=0, rx_empty=1, rx_full=0, frame_err=0, overrun=0, FSM=IDLE, FIFO pointers=0, tick counter=0, synchronizer flops=1.
- Synchronizer: two-flop synchronizer on rx; all FSM decisions use the synchronized value rxs.
- Tick generator: free-running counter 0..DVSR-1; tick=1 for one cycle when count==DVSR-1, then the counter wraps to 0. It runs continuously and is not resynchronized to the start edge.
- FSM (4 states), with s = tick counter 0..15 and n = bit counter 0..DBIT-1:
  - IDLE: when rxs==0, go to START with s=0.
  - START: on each tick, if s==7 (mid start bit): if rxs==0, go to DATA with s=0, n=0; else go to IDLE (glitch rejected, no flag). Otherwise s++.
  - DATA: on each tick, if s==15: shift rxs into the MSB of the shift register (LSB-first reception), s=0; if n==DBIT-1 go to STOP, else n++. Otherwise s++.
  - STOP: on each tick, if s==SB_TICK-1: if rxs==1, push the shift register into the FIFO; if rxs==0, set frame_err and discard the byte. Then go to IDLE. Otherwise s++.
- Push-result latency: a push occurs on the edge of the final stop tick. rx_empty deasserts and r_data is valid on the next cycle.
- FIFO rules:
  - Push while full without a simultaneous pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both performed, no overrun, rx_full stays 1.
  - Push and pop in the same cycle while empty: push only, pop ignored.
  - Pop while empty: ignored.
  - Pointers wrap modulo depth.
  - rx_full = (count==depth); rx_empty = (count==0).
- Error flags: frame_err and overrun hold until clr_err=1. If a set and clr_err coincide in the same cycle, set wins.
- Back-to-back characters: a new start bit is accepted immediately after a frame ends in STOP→IDLE; there is no inter-frame gap requirement.
- Reset mid-frame: immediate return to IDLE, partial byte lost, FIFO emptied, flags cleared. After release, a line held low is treated as a new start bit.

Test Plan (DVSR=4 for simulation, so one bit = 64 clk; 10 ns clock):
- Single byte: drive 0xA5 8N1 -> rx_empty falls after the stop bit; r_data=0xA5; one rd_uart pulse -> rx_empty=1, r_data=0; frame_err=0, overrun=0.
- Glitch: rx low for 16 clk, then high -> FSM returns to IDLE; rx_empty stays 1; no flags set.
- Framing error: send 0x3C with stop bit held low, then idle -> frame_err=1, rx_empty=1. Next, send 0x11 correctly -> 0x11 in FIFO, frame_err still 1; clr_err pulse -> frame_err=0.
- Fill/overrun: send 0x00..0x0F -> rx_full=1. Send 0xFF -> overrun=1, rx_full=1. Sixteen pops return 0x00..0x0F in order; then rx_empty=1.
- Simultaneous push and pop when full: with 16 bytes queued, assert rd_uart exactly on the stop-tick push edge of byte 0x77 -> overrun stays 0, rx_full=1, the first pop returns 0x00, and 0x77 is the last byte read.
- Reset mid-frame: assert reset during DATA of 0x5A -> all outputs return to reset values. After release, send 0xC3 -> FIFO holds only 0xC3.

Source files
------------

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver.
// The serial line, pop/clear requests, FIFO head and status flags travel together.
interface uart_rx_if #(parameter int DBIT = 8);
    logic            rx;
    logic            rd_uart;
    logic            clr_err;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rx_full;
    logic            frame_err;
    logic            overrun;

    modport master (output rx, rd_uart, clr_err,
                    input  r_data, rx_empty, rx_full, frame_err, overrun);
    modport slave  (input  rx, rd_uart, clr_err,
                    output r_data, rx_empty, rx_full, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver feeding a first-word-fall-through FIFO,
// with sticky framing and overrun flags.
module uart_rx #(
    parameter int DVSR    = 54,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 4
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int TW    = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int CW    = FIFO_W + 1;
    localparam int DEPTH = 2 ** FIFO_W;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]        r_sync;
    logic              w_rxs;
    logic [TW-1:0]     r_tick_cnt;
    logic              w_tick;
    state_t            r_state, w_state_nxt;
    logic [SW-1:0]     r_s, w_s_nxt;
    logic [NW-1:0]     r_n, w_n_nxt;
    logic [DBIT-1:0]   r_b, w_b_nxt;
    logic              w_push, w_ferr_set;
    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [FIFO_W-1:0] r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_pop, w_full, w_empty, w_wr, w_ovr_set;
    logic              r_frame_err, r_overrun;

    // rx is asynchronous; reset to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], bus.rx};
    end
    assign w_rxs = r_sync[1];

    assign w_tick = (r_tick_cnt == TW'(DVSR - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == SW'(7)) begin
                        // a line that is high again at mid start bit was a glitch
                        if (!w_rxs) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        w_b_nxt = {w_rxs, r_b[DBIT-1:1]};
                        w_s_nxt = '0;
                        if (r_n == NW'(DBIT - 1)) w_state_nxt = STOP;
                        else                      w_n_nxt     = r_n + 1'b1;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_push      = w_rxs;
                        w_ferr_set  = !w_rxs;
                        w_state_nxt = IDLE;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // a pop frees the slot this same edge, so a push while full still lands
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = bus.rd_uart && !w_empty;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_wr) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set)       r_frame_err <= 1'b1;
            else if (bus.clr_err) r_frame_err <= 1'b0;
            if (w_ovr_set)        r_overrun   <= 1'b1;
            else if (bus.clr_err) r_overrun   <= 1'b0;
        end
    end

    assign bus.r_data    = w_empty ? '0 : r_mem[r_rptr];
    assign bus.rx_empty  = w_empty;
    assign bus.rx_full   = w_full;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DVSR=4: one bit is 64 clocks of 10 ns.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;
    logic       popped;
    logic [7:0] pop_data;

    always #5 clk = ~clk;

    uart_rx_if #(.DBIT(8)) ifc ();

    uart_rx #(.DVSR(4), .DBIT(8), .SB_TICK(16), .FIFO_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stop bit driven at stop_val for stop_len clocks, then high for the rest of the bit;
    // with pop_on_push, rd_uart is raised for exactly the push edge of this frame
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len,
                             input bit pop_on_push);
        ifc.rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ifc.rx = b[i];
            repeat (64) @(negedge clk);
        end
        ifc.rx = stop_val;
        for (int c = 0; c < stop_len; c++) begin
            if (pop_on_push && !popped && dut.w_push) begin
                pop_data    = ifc.r_data;
                popped      = 1'b1;
                ifc.rd_uart = 1'b1;
            end else begin
                ifc.rd_uart = 1'b0;
            end
            @(negedge clk);
        end
        ifc.rd_uart = 1'b0;
        ifc.rx      = 1'b1;
        if (stop_len < 64) repeat (64 - stop_len) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, ifc.r_data, exp);
        ifc.rd_uart = 1'b1;
        @(negedge clk);
        ifc.rd_uart = 1'b0;
    endtask

    task automatic clr_pulse();
        ifc.clr_err = 1'b1;
        @(negedge clk);
        ifc.clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        ifc.rx      = 1'b1;
        ifc.rd_uart = 1'b0;
        ifc.clr_err = 1'b0;
        popped      = 1'b0;
        pop_data    = '0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", ifc.r_data, 8'h00);
        chk("rst_empty", ifc.rx_empty, 1'b1);
        chk("rst_full", ifc.rx_full, 1'b0);
        chk("rst_ferr", ifc.frame_err, 1'b0);
        chk("rst_ovr", ifc.overrun, 1'b0);

        // single byte
        send_byte(8'hA5, 1'b1, 64, 1'b0);
        chk("a5_empty", ifc.rx_empty, 1'b0);
        pop_chk("a5_data", 8'hA5);
        chk("a5_empty_after", ifc.rx_empty, 1'b1);
        chk("a5_rdata_after", ifc.r_data, 8'h00);
        chk("a5_ferr", ifc.frame_err, 1'b0);
        chk("a5_ovr", ifc.overrun, 1'b0);

        // 16-clock glitch is rejected at mid start bit
        ifc.rx = 1'b0;
        repeat (16) @(negedge clk);
        ifc.rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_empty", ifc.rx_empty, 1'b1);
        chk("glitch_ferr", ifc.frame_err, 1'b0);
        chk("glitch_ovr", ifc.overrun, 1'b0);

        // framing error, then a good byte, then clear
        send_byte(8'h3C, 1'b0, 48, 1'b0);
        repeat (128) @(negedge clk);
        chk("fe_flag", ifc.frame_err, 1'b1);
        chk("fe_empty", ifc.rx_empty, 1'b1);
        send_byte(8'h11, 1'b1, 64, 1'b0);
        chk("fe_next_data", ifc.r_data, 8'h11);
        chk("fe_sticky", ifc.frame_err, 1'b1);
        clr_pulse();
        chk("fe_cleared", ifc.frame_err, 1'b0);
        pop_chk("fe_pop11", 8'h11);
        chk("fe_empty_end", ifc.rx_empty, 1'b1);

        // fill and overrun
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 64, 1'b0);
        chk("fill_full", ifc.rx_full, 1'b1);
        chk("fill_ovr0", ifc.overrun, 1'b0);
        send_byte(8'hFF, 1'b1, 64, 1'b0);
        chk("ovr_flag", ifc.overrun, 1'b1);
        chk("ovr_full", ifc.rx_full, 1'b1);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("fill_pop%0d", i), 8'(i));
        chk("fill_empty", ifc.rx_empty, 1'b1);
        chk("fill_rdata0", ifc.r_data, 8'h00);
        clr_pulse();
        chk("ovr_cleared", ifc.overrun, 1'b0);

        // push and pop on the same edge while full
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 64, 1'b0);
        chk("sim_full_pre", ifc.rx_full, 1'b1);
        popped = 1'b0;
        send_byte(8'h77, 1'b1, 64, 1'b1);
        chk("sim_push_seen", popped, 1'b1);
        chk("sim_first_pop", pop_data, 8'h00);
        chk("sim_ovr", ifc.overrun, 1'b0);
        chk("sim_full", ifc.rx_full, 1'b1);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("sim_pop%0d", i), 8'(i));
        pop_chk("sim_last77", 8'h77);
        chk("sim_empty", ifc.rx_empty, 1'b1);

        // reset in the middle of a frame with a byte already queued
        send_byte(8'h99, 1'b1, 64, 1'b0);
        chk("mid_queued", ifc.r_data, 8'h99);
        ifc.rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ifc.rx = i[0] ? 1'b1 : 1'b0;
            repeat (64) @(negedge clk);
        end
        reset  = 1'b1;
        ifc.rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rdata", ifc.r_data, 8'h00);
        chk("mid_empty", ifc.rx_empty, 1'b1);
        chk("mid_full", ifc.rx_full, 1'b0);
        chk("mid_ferr", ifc.frame_err, 1'b0);
        chk("mid_ovr", ifc.overrun, 1'b0);
        repeat (700) @(negedge clk);
        chk("mid_idle_empty", ifc.rx_empty, 1'b1);
        send_byte(8'hC3, 1'b1, 64, 1'b0);
        pop_chk("mid_c3", 8'hC3);
        chk("mid_only_c3", ifc.rx_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
